periph_bus_dma: RTL and testbench



---
 rtl/periph_bus_pkg.sv | 16 +
 rtl/periph_bus_dma.sv | 149 ++++++++++++++
 tb/tb_periph_bus_dma.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_pkg.sv
// Shared peripheral-bus constants and the word-copy engine state encoding.
package periph_bus_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

endpackage

// File: rtl/periph_bus_dma.sv
// Peripheral-bus word-copy initiator: read source word, wait read latency, write destination.
// Define PERIPH_BUS_DMA_ABORT_EN to add the Abort input.
//
// state | meaning
// IDLE  | waiting for Start
// REQ   | BusReq high, waiting for BusGrant
// READ  | read strobe on source address
// WAIT  | counting down read latency, capture data on last cycle
// WRITE | write strobe on destination address, advance pointers
// DONE  | one-cycle Done pulse, bus released
module periph_bus_dma
    import periph_bus_pkg::*;
#(
    parameter int LEN_W        = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic              CoreClock,
    input  logic              ResetN,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Length,
`ifdef PERIPH_BUS_DMA_ABORT_EN
    input  logic              Abort,
`endif
    output logic              Busy,
    output logic              Done,
    output logic [LEN_W-1:0]  WordsDone,
    output logic              BusReq,
    input  logic              BusGrant,
    output logic [ADDR_W-1:0] AddressBus_P,
    output logic [DATA_W-1:0] DataWriteBus_P,
    output logic              WriteAssert_P,
    output logic              ReadAssert_P,
    input  logic [DATA_W-1:0] DataReadBus_p
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    dma_state_t        state;
    logic [ADDR_W-1:0] srcPtr;
    logic [ADDR_W-1:0] dstPtr;
    logic [LEN_W-1:0]  remaining;
    logic [LAT_W-1:0]  latCnt;
    logic              abortReq;

`ifdef PERIPH_BUS_DMA_ABORT_EN
    assign abortReq = Abort;
`else
    assign abortReq = 1'b0;
`endif

    // Outputs are loaded on the edge that enters the state they decode, so
    // DataWriteBus_P doubles as the read-data hold register during WRITE.
    always_ff @(posedge CoreClock or negedge ResetN) begin
        if (!ResetN) begin
            state          <= IDLE;
            srcPtr         <= '0;
            dstPtr         <= '0;
            remaining      <= '0;
            latCnt         <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            WordsDone      <= '0;
            BusReq         <= 1'b0;
            AddressBus_P   <= '0;
            DataWriteBus_P <= '0;
            WriteAssert_P  <= 1'b0;
            ReadAssert_P   <= 1'b0;
        end else begin
            Done           <= 1'b0;
            ReadAssert_P   <= 1'b0;
            WriteAssert_P  <= 1'b0;
            AddressBus_P   <= '0;
            DataWriteBus_P <= '0;

            if (abortReq && (state == REQ || state == READ || state == WAIT)) begin
                state  <= DONE;
                Done   <= 1'b1;
                BusReq <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (Start) begin
                            Busy      <= 1'b1;
                            WordsDone <= '0;
                            if (Length != '0) begin
                                state     <= REQ;
                                srcPtr    <= SrcAddr;
                                dstPtr    <= DstAddr;
                                remaining <= Length;
                                BusReq    <= 1'b1;
                            end else begin
                                state <= DONE;
                                Done  <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        if (BusGrant) begin
                            state        <= READ;
                            ReadAssert_P <= 1'b1;
                            AddressBus_P <= srcPtr;
                        end
                    end
                    READ: begin
                        state  <= WAIT;
                        latCnt <= LAT_W'(READ_LATENCY);
                    end
                    WAIT: begin
                        if (latCnt == LAT_W'(1)) begin
                            state          <= WRITE;
                            latCnt         <= '0;
                            WriteAssert_P  <= 1'b1;
                            AddressBus_P   <= dstPtr;
                            DataWriteBus_P <= DataReadBus_p;
                        end else begin
                            latCnt <= latCnt - LAT_W'(1);
                        end
                    end
                    WRITE: begin
                        srcPtr    <= srcPtr + ADDR_W'(1);
                        dstPtr    <= dstPtr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        WordsDone <= WordsDone + LEN_W'(1);
                        if (remaining == LEN_W'(1) || abortReq) begin
                            state  <= DONE;
                            Done   <= 1'b1;
                            BusReq <= 1'b0;
                        end else if (BusGrant) begin
                            state        <= READ;
                            ReadAssert_P <= 1'b1;
                            AddressBus_P <= srcPtr + ADDR_W'(1);
                        end else begin
                            state <= REQ;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        Busy   <= 1'b0;
                        BusReq <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_dma.sv
// Self-checking bench for periph_bus_dma: responder model plus word-list reference model.
`timescale 1ns/1ps
module tb_periph_bus_dma;
    import periph_bus_pkg::*;

    localparam int LEN_W = 14;
    localparam int LAT   = 1;
    localparam int WORD_CYC = 2 + LAT;

    logic CoreClock = 1'b0;
    logic ResetN    = 1'b0;
    logic Start     = 1'b0;
    logic BusGrant  = 1'b0;
    logic [ADDR_W-1:0] SrcAddr = '0;
    logic [ADDR_W-1:0] DstAddr = '0;
    logic [LEN_W-1:0]  Length  = '0;
    logic [DATA_W-1:0] DataReadBus_p = 32'hDEAD_BEEF;
`ifdef PERIPH_BUS_DMA_ABORT_EN
    logic Abort = 1'b0;
`endif
    logic              Busy, Done, BusReq, WriteAssert_P, ReadAssert_P;
    logic [LEN_W-1:0]  WordsDone;
    logic [ADDR_W-1:0] AddressBus_P;
    logic [DATA_W-1:0] DataWriteBus_P;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [DATA_W-1:0] salt = '0;
    logic [ADDR_W-1:0] wrAddrQ[$];
    logic [DATA_W-1:0] wrDataQ[$];
    logic [ADDR_W-1:0] rdAddrQ[$];
    int doneCnt  = 0;
    int reqCnt   = 0;
    int protoErr = 0;

    logic              pipeV[LAT];
    logic [ADDR_W-1:0] pipeA[LAT];
    logic              sampRd = 1'b0;
    logic [ADDR_W-1:0] sampA  = '0;

    periph_bus_dma #(.LEN_W(LEN_W), .READ_LATENCY(LAT)) dut (
        .CoreClock(CoreClock), .ResetN(ResetN), .Start(Start),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
`ifdef PERIPH_BUS_DMA_ABORT_EN
        .Abort(Abort),
`endif
        .Busy(Busy), .Done(Done), .WordsDone(WordsDone),
        .BusReq(BusReq), .BusGrant(BusGrant),
        .AddressBus_P(AddressBus_P), .DataWriteBus_P(DataWriteBus_P),
        .WriteAssert_P(WriteAssert_P), .ReadAssert_P(ReadAssert_P),
        .DataReadBus_p(DataReadBus_p)
    );

    always #5 CoreClock = ~CoreClock;

    function automatic logic [DATA_W-1:0] rspData(input logic [ADDR_W-1:0] a);
        return salt ^ (32'h0000_00A0 + DATA_W'(a));
    endfunction

    // Responder: read data valid only on the edge LAT cycles after the sampling edge.
    initial for (int i = 0; i < LAT; i++) begin pipeV[i] = 1'b0; pipeA[i] = '0; end
    always @(posedge CoreClock) begin
        #1;
        for (int i = LAT - 1; i > 0; i--) begin pipeV[i] = pipeV[i-1]; pipeA[i] = pipeA[i-1]; end
        pipeV[0] = sampRd;
        pipeA[0] = sampA;
        DataReadBus_p = pipeV[LAT-1] ? rspData(pipeA[LAT-1]) : 32'hDEAD_BEEF;
    end

    always @(negedge CoreClock) begin
        sampRd = ReadAssert_P;
        sampA  = AddressBus_P;
        if (ReadAssert_P) rdAddrQ.push_back(AddressBus_P);
        if (WriteAssert_P) begin
            wrAddrQ.push_back(AddressBus_P);
            wrDataQ.push_back(DataWriteBus_P);
        end
        if (Done) doneCnt++;
        if (BusReq) reqCnt++;
        if (ReadAssert_P && WriteAssert_P) protoErr++;
        if (!ReadAssert_P && !WriteAssert_P && (AddressBus_P != '0 || DataWriteBus_P != '0)) protoErr++;
        if (ReadAssert_P && DataWriteBus_P != '0) protoErr++;
        if (Busy && !Done && !BusReq) protoErr++;
        if (!Busy && (BusReq || Done || ReadAssert_P || WriteAssert_P)) protoErr++;
    end

    task automatic clear_log();
        wrAddrQ.delete(); wrDataQ.delete(); rdAddrQ.delete();
        doneCnt = 0; reqCnt = 0;
    endtask

    // Issues one command and waits for Done; lat = edges from Start edge to Done high, -1 on timeout.
    task automatic run_cmd(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [LEN_W-1:0] n, input bit randGrant, output int lat);
        int edges;
        @(negedge CoreClock);
        SrcAddr = s; DstAddr = d; Length = n; Start = 1'b1;
        @(negedge CoreClock);
        Start = 1'b0;
        edges = 1;
        while (!Done && edges < 3000) begin
            if (randGrant) BusGrant = ($urandom_range(0, 3) != 0);
            @(negedge CoreClock);
            edges++;
        end
        lat = Done ? edges - 1 : -1;
        @(negedge CoreClock);
        #1;
    endtask

    task automatic test_reset();
        logic [64:0] snap;
        #3;
        snap = {Busy, Done, WordsDone, BusReq, WriteAssert_P, ReadAssert_P, AddressBus_P, DataWriteBus_P};
        nCompared++;
        if (snap !== 65'd0) begin nMismatched++; $display("FAIL reset_outputs: got %h want 0", snap); end
        @(negedge CoreClock); ResetN = 1'b1;
        repeat (2) @(negedge CoreClock);
        snap = {Busy, Done, WordsDone, BusReq, WriteAssert_P, ReadAssert_P, AddressBus_P, DataWriteBus_P};
        nCompared++;
        if (snap !== 65'd0) begin nMismatched++; $display("FAIL idle_outputs: got %h want 0", snap); end
    endtask

    task automatic test_basic();
        int lat;
        salt = '0; BusGrant = 1'b1; clear_log();
        run_cmd(14'h0010, 14'h0100, 3, 1'b0, lat);
        nCompared++;
        if (lat !== 1 + 3 * WORD_CYC) begin nMismatched++; $display("FAIL basic_latency: got %0d want %0d", lat, 1 + 3 * WORD_CYC); end
        nCompared++;
        if (wrAddrQ.size() !== 3) begin nMismatched++; $display("FAIL basic_wcount: got %0d want 3", wrAddrQ.size()); end
        for (int i = 0; i < 3 && i < wrAddrQ.size(); i++) begin
            nCompared++;
            if (wrAddrQ[i] !== 14'h0100 + 14'(i) || wrDataQ[i] !== 32'hB0 + 32'(i)) begin
                nMismatched++;
                $display("FAIL basic_word%0d: got %h<=%h want %h<=%h", i, wrAddrQ[i], wrDataQ[i], 14'h0100 + 14'(i), 32'hB0 + 32'(i));
            end
        end
        nCompared++;
        if (WordsDone !== 14'd3 || Busy !== 1'b0 || doneCnt !== 1) begin
            nMismatched++; $display("FAIL basic_status: got words=%0d busy=%b done=%0d want 3 0 1", WordsDone, Busy, doneCnt);
        end
    endtask

    task automatic test_zero_len();
        int lat;
        BusGrant = 1'b0; clear_log();
        run_cmd(ADDR_W'($urandom), ADDR_W'($urandom), 0, 1'b0, lat);
        nCompared++;
        if (lat !== 0) begin nMismatched++; $display("FAIL zero_latency: got %0d want 0", lat); end
        nCompared++;
        if (rdAddrQ.size() !== 0 || wrAddrQ.size() !== 0 || reqCnt !== 0 || doneCnt !== 1) begin
            nMismatched++;
            $display("FAIL zero_bus: got rd=%0d wr=%0d req=%0d done=%0d want 0 0 0 1", rdAddrQ.size(), wrAddrQ.size(), reqCnt, doneCnt);
        end
    endtask

    task automatic test_grant_gap();
        logic [ADDR_W-1:0] s, d;
        int bad, k, lat;
        s = ADDR_W'($urandom); d = ADDR_W'($urandom); salt = $urandom;
        BusGrant = 1'b0; clear_log(); bad = 0;
        @(negedge CoreClock);
        SrcAddr = s; DstAddr = d; Length = 2; Start = 1'b1;
        @(negedge CoreClock); Start = 1'b0; k = 1;
        repeat (5) begin
            if (BusReq !== 1'b1 || ReadAssert_P !== 1'b0 || WriteAssert_P !== 1'b0) bad++;
            @(negedge CoreClock); k++;
        end
        BusGrant = 1'b1;
        while (!WriteAssert_P && k < 200) begin @(negedge CoreClock); k++; end
        BusGrant = 1'b0;
        @(negedge CoreClock); k++;
        repeat (4) begin
            if (BusReq !== 1'b1 || ReadAssert_P !== 1'b0 || WriteAssert_P !== 1'b0) bad++;
            @(negedge CoreClock); k++;
        end
        BusGrant = 1'b1;
        while (!Done && k < 400) begin @(negedge CoreClock); k++; end
        lat = Done ? k - 1 : -1;
        @(negedge CoreClock); #1;
        nCompared++;
        if (bad !== 0) begin nMismatched++; $display("FAIL gap_ungranted: got %0d bad cycles want 0", bad); end
        nCompared++;
        if (lat !== 1 + 2 * WORD_CYC + 5 + 1 + 4) begin nMismatched++; $display("FAIL gap_latency: got %0d want %0d", lat, 1 + 2 * WORD_CYC + 10); end
        nCompared++;
        if (wrAddrQ.size() !== 2 || WordsDone !== 14'd2) begin
            nMismatched++; $display("FAIL gap_count: got wr=%0d words=%0d want 2 2", wrAddrQ.size(), WordsDone);
        end
        for (int i = 0; i < 2 && i < wrAddrQ.size(); i++) begin
            nCompared++;
            if (wrAddrQ[i] !== d + ADDR_W'(i) || wrDataQ[i] !== rspData(s + ADDR_W'(i))) begin
                nMismatched++; $display("FAIL gap_word%0d: got %h<=%h want %h<=%h", i, wrAddrQ[i], wrDataQ[i], d + ADDR_W'(i), rspData(s + ADDR_W'(i)));
            end
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] d;
        int k, lat;
        d = ADDR_W'($urandom); salt = $urandom; BusGrant = 1'b1; clear_log();
        @(negedge CoreClock);
        SrcAddr = 14'h3FFF; DstAddr = d; Length = 2; Start = 1'b1;
        @(negedge CoreClock); Start = 1'b0; k = 1;
        repeat (3) begin @(negedge CoreClock); k++; end
        SrcAddr = 14'h0123; DstAddr = 14'h0456; Length = 7; Start = 1'b1;
        @(negedge CoreClock); k++; Start = 1'b0;
        while (!Done && k < 200) begin @(negedge CoreClock); k++; end
        lat = Done ? k - 1 : -1;
        repeat (6) @(negedge CoreClock);
        #1;
        nCompared++;
        if (lat !== 1 + 2 * WORD_CYC) begin nMismatched++; $display("FAIL wrap_latency: got %0d want %0d", lat, 1 + 2 * WORD_CYC); end
        nCompared++;
        if (rdAddrQ.size() !== 2 || Busy !== 1'b0 || doneCnt !== 1) begin
            nMismatched++; $display("FAIL wrap_restart: got rd=%0d busy=%b done=%0d want 2 0 1", rdAddrQ.size(), Busy, doneCnt);
        end else begin
            nCompared++;
            if (rdAddrQ[0] !== 14'h3FFF || rdAddrQ[1] !== 14'h0000) begin
                nMismatched++; $display("FAIL wrap_reads: got %h %h want 3fff 0000", rdAddrQ[0], rdAddrQ[1]);
            end
        end
        nCompared++;
        if (wrAddrQ.size() !== 2 || wrDataQ[1] !== rspData(14'h0000) || wrAddrQ[1] !== d + ADDR_W'(1)) begin
            nMismatched++; $display("FAIL wrap_writes: got n=%0d want 2 words ending %h<=%h", wrAddrQ.size(), d + ADDR_W'(1), rspData(14'h0000));
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] snap;
        logic [ADDR_W-1:0] s, d;
        int nr, k, lat;
        BusGrant = 1'b1; clear_log(); salt = $urandom; nr = 0; k = 0;
        @(negedge CoreClock);
        SrcAddr = ADDR_W'($urandom); DstAddr = ADDR_W'($urandom); Length = 4; Start = 1'b1;
        @(negedge CoreClock); Start = 1'b0;
        while (k < 100) begin
            if (ReadAssert_P) nr++;
            if (nr == 2) break;
            @(negedge CoreClock); k++;
        end
        nCompared++;
        if (nr !== 2) begin nMismatched++; $display("FAIL rmid_reach: got %0d reads want 2", nr); end
        @(negedge CoreClock);
        #2 ResetN = 1'b0;
        #1;
        snap = {Busy, Done, WordsDone, BusReq, WriteAssert_P, ReadAssert_P, AddressBus_P, DataWriteBus_P};
        nCompared++;
        if (snap !== 65'd0) begin nMismatched++; $display("FAIL rmid_outputs: got %h want 0", snap); end
        repeat (2) @(negedge CoreClock);
        ResetN = 1'b1;
        repeat (2) @(negedge CoreClock);
        #1;
        nCompared++;
        if (doneCnt !== 0 || WordsDone !== '0) begin
            nMismatched++; $display("FAIL rmid_nodone: got done=%0d words=%0d want 0 0", doneCnt, WordsDone);
        end
        s = ADDR_W'($urandom); d = ADDR_W'($urandom); clear_log();
        run_cmd(s, d, 3, 1'b0, lat);
        nCompared++;
        if (lat !== 1 + 3 * WORD_CYC || WordsDone !== 14'd3 || wrAddrQ.size() !== 3) begin
            nMismatched++; $display("FAIL rmid_rerun: got lat=%0d words=%0d wr=%0d want %0d 3 3", lat, WordsDone, wrAddrQ.size(), 1 + 3 * WORD_CYC);
        end else begin
            nCompared++;
            if (wrDataQ[2] !== rspData(s + ADDR_W'(2)) || wrAddrQ[2] !== d + ADDR_W'(2)) begin
                nMismatched++; $display("FAIL rmid_data: got %h<=%h want %h<=%h", wrAddrQ[2], wrDataQ[2], d + ADDR_W'(2), rspData(s + ADDR_W'(2)));
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] s, d;
        int n, lat;
        bit rg;
        for (int it = 0; it < 8; it++) begin
            s = ADDR_W'($urandom); d = ADDR_W'($urandom); n = $urandom_range(1, 6);
            if (it == 2) s = 14'h3FFD;
            rg = (it % 2) == 1; salt = $urandom; BusGrant = 1'b1; clear_log();
            run_cmd(s, d, LEN_W'(n), rg, lat);
            BusGrant = 1'b1;
            nCompared++;
            if (lat < 0 || (!rg && lat !== 1 + n * WORD_CYC)) begin
                nMismatched++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, 1 + n * WORD_CYC);
            end
            nCompared++;
            if (wrAddrQ.size() !== n || rdAddrQ.size() !== n || WordsDone !== LEN_W'(n) || doneCnt !== 1) begin
                nMismatched++;
                $display("FAIL rand%0d_count: got wr=%0d rd=%0d words=%0d done=%0d want %0d", it, wrAddrQ.size(), rdAddrQ.size(), WordsDone, doneCnt, n);
            end
            for (int i = 0; i < n && i < wrAddrQ.size() && i < rdAddrQ.size(); i++) begin
                nCompared++;
                if (rdAddrQ[i] !== s + ADDR_W'(i) || wrAddrQ[i] !== d + ADDR_W'(i) || wrDataQ[i] !== rspData(s + ADDR_W'(i))) begin
                    nMismatched++;
                    $display("FAIL rand%0d_word%0d: got rd=%h wr=%h<=%h want rd=%h wr=%h<=%h", it, i, rdAddrQ[i], wrAddrQ[i], wrDataQ[i],
                             s + ADDR_W'(i), d + ADDR_W'(i), rspData(s + ADDR_W'(i)));
                end
            end
        end
    endtask

`ifdef PERIPH_BUS_DMA_ABORT_EN
    task automatic test_abort();
        int k, seen;
        for (int mode = 0; mode < 2; mode++) begin
            BusGrant = 1'b1; clear_log(); salt = $urandom; k = 0; seen = 0;
            @(negedge CoreClock);
            SrcAddr = ADDR_W'($urandom); DstAddr = ADDR_W'($urandom); Length = 5; Start = 1'b1;
            @(negedge CoreClock); Start = 1'b0;
            while (k < 200) begin
                if ((mode == 0) ? ReadAssert_P : WriteAssert_P) seen++;
                if (seen == 3) break;
                @(negedge CoreClock); k++;
            end
            if (mode == 0) @(negedge CoreClock);
            Abort = 1'b1;
            @(negedge CoreClock); Abort = 1'b0;
            while (!Done && k < 300) begin @(negedge CoreClock); k++; end
            repeat (2) @(negedge CoreClock);
            #1;
            nCompared++;
            if (doneCnt !== 1 || WordsDone !== LEN_W'(2 + mode) || wrAddrQ.size() !== 2 + mode) begin
                nMismatched++;
                $display("FAIL abort%0d: got done=%0d words=%0d wr=%0d want 1 %0d %0d", mode, doneCnt, WordsDone, wrAddrQ.size(), 2 + mode, 2 + mode);
            end
        end
        clear_log();
        Abort = 1'b1;
        repeat (3) @(negedge CoreClock);
        Abort = 1'b0;
        #1;
        nCompared++;
        if (Busy !== 1'b0 || doneCnt !== 0) begin nMismatched++; $display("FAIL abort_idle: got busy=%b done=%0d want 0 0", Busy, doneCnt); end
    endtask
`endif

    task automatic test_protocol();
        nCompared++;
        if (protoErr !== 0) begin nMismatched++; $display("FAIL protocol: got %0d violations want 0", protoErr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_grant_gap();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef PERIPH_BUS_DMA_ABORT_EN
        test_abort();
`endif
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
